ac_control_unit: RTL and testbench

- Instruction sequencer for the 8-bit accumulator computer; sits directly upstream of the ALU.
- Fetches instructions over a simple memory handshake and holds PC, IR, MAR, MDR, accumulator and the flag register.
- Drives the ALU operands and `op`, then captures the ALU result and flags back into the accumulator and flag register.

---
 rtl/ac_control_unit_if.sv | 46 ++++
 rtl/ac_control_unit.sv | 157 +++++++++++++++
 tb/tb_ac_control_unit.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_control_unit_if.sv
// rtl/ac_control_unit_if.sv - memory handshake and ALU operand/result bundle for ac_control_unit
//
// Purpose: groups the memory transfer handshake and the ALU connection of the
// accumulator sequencer. Signal suffixes are from the sequencer's point of view.
//
// master (sequencer): drives mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o and
//                     alu_x_o/alu_y_o/alu_op_o; receives mem_rdata_i/mem_ack_i
//                     and alu_r_i/alu_flags_i.
// slave  (memory + ALU side): the mirror image.
//   mem_req_o    transfer request, held until an edge with mem_ack_i=1
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   transfer address
//   mem_wdata_o  write data (accumulator)
//   mem_rdata_i  read data, sampled on the req&ack edge
//   mem_ack_i    transfer complete
//   alu_x_o      x operand (accumulator)
//   alu_y_o      y operand (MDR)
//   alu_op_o     000 ADD, 001 SUB, 010 pass-y
//   alu_r_i      ALU result
//   alu_flags_i  [0]=Z, [1]=C

interface ac_control_unit_if;
  logic       mem_req_o;
  logic       mem_we_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;
  logic       mem_ack_i;
  logic [7:0] alu_x_o;
  logic [7:0] alu_y_o;
  logic [2:0] alu_op_o;
  logic [7:0] alu_r_i;
  logic [1:0] alu_flags_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output alu_x_o, alu_y_o, alu_op_o,
    input  mem_rdata_i, mem_ack_i, alu_r_i, alu_flags_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  alu_x_o, alu_y_o, alu_op_o,
    output mem_rdata_i, mem_ack_i, alu_r_i, alu_flags_i
  );
endinterface

// File: rtl/ac_control_unit.sv
// rtl/ac_control_unit.sv - instruction sequencer of the 8-bit accumulator computer
//
// Purpose: fetches and executes instructions over a req/ack memory handshake,
// holding PC, IR, MAR, MDR, accumulator and flags; drives the ALU that sits
// downstream and writes its result/flags back.
//
// Ports:
//   clk_i      clock, all state changes on the rising edge
//   rst_n_i    asynchronous active-low reset
//   bus        ac_control_unit_if.master (memory handshake + ALU operands/result)
//   pc_o       program counter
//   acc_o      accumulator
//   flags_o    registered flags, [0]=Z, [1]=C
//   halted_o   high once a HLT has been executed, until reset

module ac_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  ac_control_unit_if.master      bus,
  output logic [7:0]             pc_o,
  output logic [7:0]             acc_o,
  output logic [1:0]             flags_o,
  output logic                   halted_o
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH_OP,
    S_DECODE,
    S_FETCH_ADDR,
    S_READ,
    S_WB,
    S_WRITE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b010;

  state_t     state;
  logic [7:0] pc;
  logic [3:0] ir;     // only the opcode nibble matters; the low nibble is ignored
  logic [7:0] mar;
  logic [7:0] mdr;
  logic [7:0] acc;
  logic [1:0] flags;
  logic       halted;

  // Bus controls are pure decodes of the state register, so they are stable for
  // the whole transfer and fall immediately when the async reset clears state.
  assign bus.mem_req_o   = (state == S_FETCH_OP) || (state == S_FETCH_ADDR) ||
                           (state == S_READ)     || (state == S_WRITE);
  assign bus.mem_we_o    = (state == S_WRITE);
  assign bus.mem_addr_o  = ((state == S_READ) || (state == S_WRITE)) ? mar : pc;
  assign bus.mem_wdata_o = acc;

  assign bus.alu_x_o  = acc;
  assign bus.alu_y_o  = mdr;
  assign bus.alu_op_o = (state != S_WB) ? ALU_PASS :
                        (ir == OP_ADD)  ? ALU_ADD  :
                        (ir == OP_SUB)  ? ALU_SUB  : ALU_PASS;

  assign pc_o     = pc;
  assign acc_o    = acc;
  assign flags_o  = flags;
  assign halted_o = halted;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_START;
      pc     <= RESET_PC;
      ir     <= 4'h0;
      mar    <= 8'h00;
      mdr    <= 8'h00;
      acc    <= 8'h00;
      flags  <= 2'b00;
      halted <= 1'b0;
    end else begin
      case (state)
        S_START: state <= S_FETCH_OP;

        S_FETCH_OP: begin
          if (bus.mem_ack_i) begin
            ir    <= bus.mem_rdata_i[7:4];
            pc    <= pc + 8'd1;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (ir)
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_LDA, OP_STA, OP_ADD, OP_SUB,
            OP_JMP, OP_JZ, OP_JC: state <= S_FETCH_ADDR;
            default: state <= S_FETCH_OP;
          endcase
        end

        S_FETCH_ADDR: begin
          if (bus.mem_ack_i) begin
            // Defaults cover the not-taken jump; later assignments override.
            mar   <= bus.mem_rdata_i;
            pc    <= pc + 8'd1;
            state <= S_FETCH_OP;
            case (ir)
              OP_JMP: pc <= bus.mem_rdata_i;
              OP_JZ:  if (flags[0]) pc <= bus.mem_rdata_i;
              OP_JC:  if (flags[1]) pc <= bus.mem_rdata_i;
              OP_STA: state <= S_WRITE;
              OP_LDA, OP_ADD, OP_SUB: state <= S_READ;
              default: ;
            endcase
          end
        end

        S_READ: begin
          if (bus.mem_ack_i) begin
            mdr   <= bus.mem_rdata_i;
            state <= S_WB;
          end
        end

        S_WB: begin
          acc <= bus.alu_r_i;
          // A load only updates Z; the carry from an earlier ADD/SUB survives it.
          if ((ir == OP_ADD) || (ir == OP_SUB)) flags <= bus.alu_flags_i;
          else flags[0] <= bus.alu_flags_i[0];
          state <= S_FETCH_OP;
        end

        S_WRITE: begin
          if (bus.mem_ack_i) state <= S_FETCH_OP;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_control_unit.sv
// tb/tb_ac_control_unit.sv - scoreboard bench for ac_control_unit with ISA-level reference model

module tb_ac_control_unit;
  localparam logic [7:0] RP = 8'h00;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic [7:0] acc;
  logic [1:0] flags;
  logic       halted;

  ac_control_unit_if bus();

  ac_control_unit #(.RESET_PC(RP)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus),
    .pc_o     (pc),
    .acc_o    (acc),
    .flags_o  (flags),
    .halted_o (halted)
  );

  typedef struct {
    bit       we;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] acc;
    bit [1:0] flags;
  } xfer_t;

  xfer_t    exp_q[$];
  bit [7:0] mem [256];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       rel = 0;
  int       wait_fixed = 0;   // -1: random 0..3 wait cycles per transfer
  int       wleft = -1;
  bit       resp_en = 1;
  bit       sb_on = 0;
  bit       chk_hold = 0;
  bit       exp_halt;
  int       exp_acc, exp_flags, exp_pc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural ALU: ADD carry-out, SUB borrow, pass-y clears carry.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (bus.alu_op_o)
      3'b000:  alu_sum = {1'b0, bus.alu_x_o} + {1'b0, bus.alu_y_o};
      3'b001:  alu_sum = {1'b0, bus.alu_x_o} - {1'b0, bus.alu_y_o};
      default: alu_sum = {1'b0, bus.alu_y_o};
    endcase
    bus.alu_r_i     = alu_sum[7:0];
    bus.alu_flags_i = {alu_sum[8], alu_sum[7:0] == 8'd0};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: inserts wait cycles, then raises ack for one cycle.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (!rst_n || !bus.mem_req_o) begin
          bus.mem_ack_i = 1'b0;
          wleft = -1;
        end else begin
          if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            wleft = -1;
          end
          if (wleft < 0) wleft = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
          if (wleft == 0) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
            else bus.mem_rdata_i = mem[bus.mem_addr_o];
            bus.mem_ack_i = 1'b1;
            wleft = -1;
          end else begin
            wleft--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every completing transfer is matched against the model.
  initial forever begin
    xfer_t e;
    @(negedge clk);
    #1;
    if (sb_on && rst_n && bus.mem_req_o && bus.mem_ack_i) begin
      if (exp_q.size() == 0) begin
        chk("extra_xfer", int'(bus.mem_addr_o) + 256, 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_we", bus.mem_we_o, e.we);
        chk("xfer_addr", bus.mem_addr_o, e.addr);
        if (e.we) chk("xfer_wdata", bus.mem_wdata_o, e.wdata);
        chk("xfer_acc", acc, e.acc);
        chk("xfer_flags", flags, e.flags);
      end
    end
  end

  // Request stability: address/direction held and transfer length under fixed waits.
  initial begin
    bit       pend = 0;
    int       hold = 0;
    bit [7:0] h_addr;
    bit       h_we;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !bus.mem_req_o) begin
        pend = 0;
      end else begin
        if (!pend) begin
          hold = 1;
          h_addr = bus.mem_addr_o;
          h_we = bus.mem_we_o;
        end else begin
          hold++;
          if (chk_hold) begin
            chk("hold_addr", bus.mem_addr_o, h_addr);
            chk("hold_we", bus.mem_we_o, h_we);
          end
        end
        if (bus.mem_ack_i) begin
          if (chk_hold) chk("hold_len", hold, wait_fixed + 1);
          pend = 0;
        end else begin
          pend = 1;
        end
      end
    end
  end

  function automatic void push(input bit we, input int addr, input int wdata,
                               input int a, input int z, input int c);
    xfer_t e;
    e.we = we;
    e.addr = 8'(addr);
    e.wdata = 8'(wdata);
    e.acc = 8'(a);
    e.flags = {c[0], z[0]};
    exp_q.push_back(e);
  endfunction

  // Instruction-level reference: lists the expected bus transfers in order.
  task automatic model_run(input int max_instr);
    int m [256];
    int p, a, z, c, op, ad, d;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    p = RP; a = 0; z = 0; c = 0;
    exp_halt = 0;
    for (int n = 0; n < max_instr; n++) begin
      push(0, p, 0, a, z, c);
      op = m[p] / 16;
      p = (p + 1) % 256;
      if (op == 15) begin
        exp_halt = 1;
        break;
      end
      if (op >= 1 && op <= 7) begin
        push(0, p, 0, a, z, c);
        ad = m[p];
        p = (p + 1) % 256;
        case (op)
          1: begin push(0, ad, 0, a, z, c); a = m[ad]; z = (a == 0); end
          2: begin push(1, ad, a, a, z, c); m[ad] = a; end
          3: begin push(0, ad, 0, a, z, c); d = a + m[ad]; c = (d > 255); a = d % 256; z = (a == 0); end
          4: begin push(0, ad, 0, a, z, c); c = (a < m[ad]); a = (a - m[ad] + 256) % 256; z = (a == 0); end
          5: p = ad;
          6: if (z != 0) p = ad;
          7: if (c != 0) p = ad;
          default: ;
        endcase
      end
    end
    exp_acc = a;
    exp_flags = c * 2 + z;
    exp_pc = p;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 0;
    sb_on = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic start_prog(input int max_instr, input int wmode);
    model_run(max_instr);
    wait_fixed = wmode;
    sb_on = 1;
    @(negedge clk);
    rst_n = 1;
    rel = cyc;
  endtask

  task automatic finish_prog(input string name);
    int i = 0;
    while (exp_q.size() > 0 && i < 4000) begin
      @(negedge clk);
      #2;
      i++;
    end
    if (exp_q.size() > 0) begin
      chk({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    if (exp_halt) begin
      i = 0;
      while (!halted && i < 50) begin
        @(negedge clk);
        #1;
        i++;
      end
      chk({name, "_halted"}, halted, 1);
      chk({name, "_pc"}, pc, exp_pc);
      chk({name, "_acc"}, acc, exp_acc);
      chk({name, "_flags"}, flags, exp_flags);
      repeat (3) begin
        @(negedge clk);
        #1;
        chk({name, "_req_after_halt"}, bus.mem_req_o, 0);
      end
    end else begin
      sb_on = 0;
    end
  endtask

  task automatic wait_req(input string name);
    int i = 0;
    while (!bus.mem_req_o && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk({name, "_req_seen"}, bus.mem_req_o, 1);
  endtask

  task automatic wait_pc(input string name, input int target, output int n);
    int r0 = cyc;
    int i = 0;
    while (pc != 8'(target) && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    n = cyc - r0;
  endtask

  task automatic wait_halt(output int n);
    int i = 0;
    while (!halted && i < 400) begin
      @(negedge clk);
      #1;
      i++;
    end
    n = cyc - rel;
  endtask

  localparam int NIB [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 15, 9};

  initial begin
    int n;
    rst_n = 0;
    clear_mem();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, RP);
    chk("rst_acc", acc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_op", bus.alu_op_o, 2);
    chk("rst_alu_y", bus.alu_y_o, 0);

    // LDA/ADD/STA/HLT with zero waits
    hold_reset();
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h10, 8'h10, 8'h30, 8'h11, 8'h20, 8'h12, 8'hF0};
    mem[8'h10] = 8'hC8;
    mem[8'h11] = 8'h50;
    start_prog(50, 0);
    wait_halt(n);
    chk("t1_edges_to_halt", n, 17);
    finish_prog("t1");
    chk("t1_acc", acc, 8'h18);
    chk("t1_flags", flags, 2'b10);
    chk("t1_pc", pc, 8'h07);
    chk("t1_mem12", mem[8'h12], 8'h18);

    // SUB to zero then JZ taken
    hold_reset();
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h10, 8'h20, 8'h40, 8'h20, 8'h60, 8'h40};
    mem[8'h20] = 8'h05;
    mem[8'h40] = 8'hF0;
    start_prog(50, 0);
    wait_req("t2");
    wait_pc("t2", 8'h40, n);
    chk("t2_edges_to_jump", n, 13);
    chk("t2_next_addr", bus.mem_addr_o, 8'h40);
    finish_prog("t2");
    chk("t2_acc", acc, 8'h00);
    chk("t2_flags", flags, 2'b01);

    // JC not taken with C=0
    hold_reset();
    clear_mem();
    {mem[0], mem[1], mem[2]} = {8'h70, 8'h80, 8'hF0};
    start_prog(50, 0);
    wait_req("t3");
    wait_pc("t3", 8'h02, n);
    chk("t3_edges", n, 3);
    chk("t3_next_addr", bus.mem_addr_o, 8'h02);
    chk("t3_next_req", bus.mem_req_o, 1);
    finish_prog("t3");

    // three wait cycles on every transfer; LDA keeps C from the preceding ADD
    hold_reset();
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h10, 8'hA0, 8'h30, 8'hA1, 8'h10, 8'h10, 8'hF0};
    mem[8'hA0] = 8'hF0;
    mem[8'hA1] = 8'h20;
    chk_hold = 1;
    start_prog(50, 3);
    wait_halt(n);
    chk("t4_edges_to_halt", n, 1 + 14 + 14 + 14 + 5);
    finish_prog("t4");
    chk_hold = 0;
    chk("t4_acc", acc, 8'h00);
    chk("t4_flags", flags, 2'b11);

    // async reset in the middle of an ADD operand read
    hold_reset();
    clear_mem();
    {mem[0], mem[1]} = {8'h30, 8'h40};
    mem[8'h40] = 8'h05;
    wait_fixed = 2;
    @(negedge clk);
    rst_n = 1;
    n = 0;
    while (!(bus.mem_req_o && bus.mem_addr_o == 8'h40) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_in_read", bus.mem_addr_o, 8'h40);
    #1;
    rst_n = 0;
    #1;
    chk("t5_req_drop", bus.mem_req_o, 0);
    chk("t5_pc", pc, RP);
    chk("t5_acc", acc, 0);
    chk("t5_flags", flags, 0);
    chk("t5_halted", halted, 0);
    chk("t5_alu_op", bus.alu_op_o, 2);
    resp_en = 0;
    @(negedge clk);
    bus.mem_ack_i = 1'b1;
    rst_n = 1;
    #1;
    chk("t5_start_no_req", bus.mem_req_o, 0);
    @(posedge clk);
    #1;
    chk("t5_first_req", bus.mem_req_o, 1);
    chk("t5_first_addr", bus.mem_addr_o, RP);
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_stale_ack_pc", pc, RP);
    chk("t5_still_fetching", bus.mem_req_o, 1);
    resp_en = 1;

    // JMP FE; the operand byte at FF wraps PC to 00
    hold_reset();
    clear_mem();
    {mem[0], mem[1]} = {8'h50, 8'hFE};
    mem[8'hFE] = 8'h10;
    mem[8'hFF] = 8'h33;
    mem[8'h33] = 8'h7A;
    start_prog(2, 0);
    finish_prog("t6");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t6_acc", acc, 8'h7A);
    chk("t6_pc", pc, 8'h00);

    // random programs with random wait states
    for (int t = 0; t < 25; t++) begin
      hold_reset();
      for (int i = 0; i < 256; i++) begin
        bit [3:0] hi;
        bit [3:0] lo;
        hi = 4'(NIB[$urandom_range(0, 9)]);
        lo = 4'($urandom);
        mem[i] = {hi, lo};
      end
      start_prog(40, -1);
      finish_prog("rand");
    end

    hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
